// File: rtl/conv_window_gen.sv
// Streaming line buffer and KxK window generator.
// Emits every fully populated neighbourhood of a raster pixel stream.
module conv_window_gen #(
    parameter int KERNEL_SIZE = 3,
    parameter int PX_SIZE     = 8,
    parameter int IMG_WIDTH   = 64,
    parameter int IMG_HEIGHT  = 64,
    localparam int XW = $clog2(IMG_WIDTH),
    localparam int YW = $clog2(IMG_HEIGHT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic [PX_SIZE-1:0] px_in,
    input  logic px_valid,
    output logic px_ready,
    output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PX_SIZE-1:0] win_out,
    output logic [XW-1:0] win_x,
    output logic [YW-1:0] win_y,
    output logic win_last,
    output logic win_valid,
    input  logic win_ready
);

    localparam int K = KERNEL_SIZE;

    logic [PX_SIZE-1:0] r_lb [K-1][IMG_WIDTH];
    logic [K-1:0][K-1:0][PX_SIZE-1:0] r_win;
    logic [K-1:0][PX_SIZE-1:0] w_colv;
    logic [XW-1:0] r_col;
    logic [YW-1:0] r_row;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic r_valid;
    logic r_last;
    logic w_acc;
    logic w_emit;
    logic w_col_end;
    logic w_row_end;

    assign px_ready  = !r_valid || win_ready;
    assign w_acc     = px_valid && px_ready;
    assign w_col_end = r_col == XW'(IMG_WIDTH - 1);
    assign w_row_end = r_row == YW'(IMG_HEIGHT - 1);
    assign w_emit    = (r_col >= XW'(K - 1)) && (r_row >= YW'(K - 1));

    assign win_out   = r_win;
    assign win_x     = r_x;
    assign win_y     = r_y;
    assign win_last  = r_last;
    assign win_valid = r_valid;

    // Column vector: oldest row on top, incoming pixel at the bottom.
    always_comb begin
        w_colv = '0;
        for (int r = 0; r < K - 1; r++) begin
            w_colv[r] = r_lb[K-2-r][r_col];
        end
        w_colv[K-1] = px_in;
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_lb[0][r_col] <= px_in;
            for (int i = 1; i < K - 1; i++) begin
                r_lb[i][r_col] <= r_lb[i-1][r_col];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win <= '0;
        end else if (w_acc) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
                r_win[r][K-1] <= w_colv[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col   <= '0;
            r_row   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_acc) begin
            r_col <= w_col_end ? '0 : r_col + 1'b1;
            if (w_col_end) begin
                r_row <= w_row_end ? '0 : r_row + 1'b1;
            end
            if (w_emit) begin
                r_valid <= 1'b1;
                r_x     <= r_col - XW'(K - 1);
                r_y     <= r_row - YW'(K - 1);
                r_last  <= w_col_end && w_row_end;
            end else if (win_ready) begin
                r_valid <= 1'b0;
            end
        end else if (win_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: 5x4 image with K=3,
// plus a minimum-size 3x3 instance.
module tb_conv_window_gen;

    typedef struct {
        logic [2:0][2:0][7:0] w;
        int x;
        int y;
        bit last;
        longint acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] px_in;
    logic px_valid;
    logic px_ready;
    logic [2:0][2:0][7:0] win_out;
    logic [2:0] win_x;
    logic [1:0] win_y;
    logic win_last;
    logic win_valid;
    logic win_ready;

    logic [7:0] m_px_in;
    logic m_px_valid;
    logic m_px_ready;
    logic [2:0][2:0][7:0] m_win_out;
    logic [1:0] m_win_x;
    logic [1:0] m_win_y;
    logic m_win_last;
    logic m_win_valid;
    logic m_win_ready;

    exp_t q[$];
    int n_run = 0;
    int n_fail = 0;
    int npop = 0;
    int mode = 0;
    int stall_n = 0;
    bit seen = 0;
    longint cyc = 0;

    conv_window_gen #(
        .KERNEL_SIZE(3), .PX_SIZE(8), .IMG_WIDTH(5), .IMG_HEIGHT(4)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .px_in(px_in), .px_valid(px_valid), .px_ready(px_ready),
        .win_out(win_out), .win_x(win_x), .win_y(win_y),
        .win_last(win_last), .win_valid(win_valid), .win_ready(win_ready)
    );

    conv_window_gen #(
        .KERNEL_SIZE(3), .PX_SIZE(8), .IMG_WIDTH(3), .IMG_HEIGHT(3)
    ) u_min (
        .clk(clk), .rst_n(rst_n),
        .px_in(m_px_in), .px_valid(m_px_valid), .px_ready(m_px_ready),
        .win_out(m_win_out), .win_x(m_win_x), .win_y(m_win_y),
        .win_last(m_win_last), .win_valid(m_win_valid),
        .win_ready(m_win_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pv(int f, int r, int c);
        return 8'(100 * f + 10 * r + c);
    endfunction

    always @(posedge clk) begin
        #1;
        case (mode)
            0: win_ready = 1'b1;
            1: win_ready = 1'($urandom_range(1, 0));
            2: begin
                if (win_valid && win_x == 3'd1 && win_y == 2'd0 &&
                    stall_n < 4) begin
                    win_ready = 1'b0;
                    stall_n++;
                end else begin
                    win_ready = 1'b1;
                end
            end
            default: win_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (!win_valid) begin
                chk("rdy_idle", px_ready, 1);
            end else if (q.size() == 0) begin
                chk("extra_win", win_valid, 0);
            end else begin
                if (!seen) begin
                    chk("latency", cyc, q[0].acc + 1);
                    seen = 1;
                end
                chk("win", win_out, q[0].w);
                chk("win_x", win_x, q[0].x);
                chk("win_y", win_y, q[0].y);
                chk("win_last", win_last, q[0].last);
                if (!win_ready) begin
                    chk("hold_rdy", px_ready, 0);
                end else begin
                    void'(q.pop_front());
                    npop++;
                    seen = 0;
                end
            end
        end
    end

    // npx = 0 sends whole frames, otherwise stops after npx pixels.
    task automatic send(input int f0, input int nfr, input bit rnd,
                        input int npx);
        int sent = 0;
        @(negedge clk);
        for (int f = f0; f < f0 + nfr; f++) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 5; c++) begin
                    int n = 0;
                    if (npx != 0 && sent >= npx) break;
                    while (rnd && $urandom_range(1, 0) == 1) begin
                        px_valid = 1'b0;
                        @(negedge clk);
                    end
                    px_valid = 1'b1;
                    px_in = pv(f, r, c);
                    while (!px_ready) begin
                        @(negedge clk);
                        n++;
                        if (n > 1000) begin
                            $display("FAIL px_timeout obs=0 exp=1");
                            $fatal(1, "pixel accept timeout");
                        end
                    end
                    if (r >= 2 && c >= 2) begin
                        exp_t e;
                        for (int i = 0; i < 3; i++)
                            for (int j = 0; j < 3; j++)
                                e.w[i][j] = pv(f, r - 2 + i, c - 2 + j);
                        e.x = c - 2;
                        e.y = r - 2;
                        e.last = (r == 3 && c == 4);
                        e.acc = cyc;
                        q.push_back(e);
                    end
                    sent++;
                    @(negedge clk);
                end
            end
        end
        px_valid = 1'b0;
    endtask

    task automatic drain(input int exp_n);
        for (int i = 0; i < 500; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        chk("drain", q.size(), 0);
        chk("count", npop, exp_n);
    endtask

    initial begin
        rst_n = 1'b0;
        px_valid = 1'b0;
        px_in = '0;
        win_ready = 1'b1;
        m_px_valid = 1'b0;
        m_px_in = '0;
        m_win_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", win_valid, 0);
        chk("rst_out", win_out, 0);
        chk("rst_x", win_x, 0);
        chk("rst_y", win_y, 0);
        chk("rst_last", win_last, 0);
        chk("rst_rdy", px_ready, 1);
        rst_n = 1'b1;

        mode = 0; npop = 0;
        send(0, 1, 0, 0);
        drain(6);

        stall_n = 0; mode = 2; npop = 0;
        send(0, 1, 0, 0);
        drain(6);
        chk("stall_cycles", stall_n, 4);

        mode = 1; npop = 0;
        send(0, 2, 1, 0);
        drain(12);

        mode = 0; npop = 0;
        repeat (2) @(negedge clk);
        send(0, 2, 0, 0);
        drain(12);

        mode = 3; npop = 0;
        repeat (2) @(negedge clk);
        send(0, 1, 0, 13);
        chk("pend_valid", win_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", win_valid, 0);
        chk("arst_x", win_x, 0);
        chk("arst_out", win_out, 0);
        q.delete();
        seen = 0;
        @(negedge clk);
        rst_n = 1'b1;
        mode = 0; npop = 0;
        send(0, 1, 0, 0);
        drain(6);

        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            m_px_valid = (i < 9);
            m_px_in = 8'(10 * (i / 3) + (i % 3));
            @(negedge clk);
            chk("min_valid", m_win_valid, (i == 8));
            if (i == 8) begin
                logic [2:0][2:0][7:0] ew;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        ew[r][c] = 8'(10 * r + c);
                chk("min_win", m_win_out, ew);
                chk("min_x", m_win_x, 0);
                chk("min_y", m_win_y, 0);
                chk("min_last", m_win_last, 1);
            end
        end
        m_px_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
